pc_controller: RTL
==================

# pc_controller

Instruction-fetch sequencer for the MIPS pipeline's IF stage. Owns the program counter register. Computes PC+4 and selects the next PC from sequential, branch and jump sources. Gates PC advance through a run/step/halt state machine driven by the debug unit and by the hazard unit's stall.

## Interface

Parameters:
- N_BITS, 32, PC and target-address width
- RESET_PC, 32'h0000_0000, PC value after reset

Ports:
- i_clk  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_run  in  1  debug unit: start continuous execution (sampled in IDLE)
- i_step  in  1  debug unit: execute one fetch cycle (sampled in IDLE)
- i_stall  in  1  hazard unit: hold PC this cycle
- i_halt  in  1  instruction at o_pc decodes as HALT
- i_jump  in  1  jump redirect request
- i_jump_addr  in  N_BITS  jump target
- i_branch  in  1  taken-branch redirect request
- i_branch_addr  in  N_BITS  branch target
- o_pc  out  N_BITS  current PC (registered)
- o_pc_4  out  N_BITS  o_pc + 4 (combinational)
- o_pc_en  out  1  PC loads next value at the coming edge (combinational)
- o_state  out  2  FSM state: IDLE=00, RUN=01, STEP=10, HALTED=11
- o_halted  out  1  registered, 1 iff state is HALTED
- o_cycles  out  32  executed-cycle counter (registered)

## Operation

- Reset values: o_pc=RESET_PC, o_state=IDLE, o_halted=0, o_cycles=0.
- o_pc_4 = o_pc + 4, modulo 2^N_BITS. No carry out; 0xFFFF_FFFC + 4 = 0x0000_0000.
- Next-PC priority: i_jump (i_jump_addr) > i_branch (i_branch_addr) > o_pc_4.
- The FSM is active in RUN or STEP.
- While active:
  - A redirect (i_jump or i_branch) always loads its target. It overrides i_stall and i_halt, so a HALT fetched on a wrong path is squashed.
  - With no redirect, the PC advances to o_pc_4 iff i_stall=0 and i_halt=0.
- While not active (IDLE, HALTED): o_pc_en=0. All redirect, stall and halt inputs are ignored.
- FSM transitions:
  - IDLE: i_run -> RUN; else i_step -> STEP. If both are high, i_run wins.
  - RUN: i_halt=1 and no redirect -> HALTED, with PC held at the HALT address. Otherwise stay in RUN. i_run and i_step are ignored.
  - STEP: exactly one cycle. i_halt=1 and no redirect -> HALTED; else -> IDLE. A stalled step still consumes the step, and the PC is unchanged.
  - HALTED: sticky; only i_reset leaves it.
- o_cycles increments by 1 at each edge taken while in RUN or STEP, including stalled cycles. It saturates at 32'hFFFF_FFFF.

## Timing

- Next-PC selection and o_pc_en are combinational. o_pc updates at the rising i_clk edge, a single-cycle path.
- i_run or i_step high in IDLE at edge k: the state is RUN/STEP after edge k, and the first PC advance happens at edge k+1.
- i_halt high in RUN at edge k: o_halted=1 after edge k, and o_pc still equals the HALT address.
- Asserting i_reset asynchronously forces all reset values immediately, mid-run or mid-step. Release is synchronous to i_clk.
- Every registered output changes only on a rising i_clk edge or on i_reset assertion.

## Configuration

- Macro: PC_DEBUG_STEP_EN.
- Defined: STEP state and i_step behave as described above.
- Undefined:
  - i_step is ignored, STEP is unreachable, and IDLE exits only on i_run.
  - o_state never reports 10.

## Test plan

- Reset then i_run pulse, no stall for 4 cycles -> o_pc sequence 0,4,8,12,16; o_cycles=5 after the 5th active edge.
- In RUN at o_pc=0x8: i_branch=1 with i_branch_addr=0x40, and i_jump=1 with i_jump_addr=0x80 in the same cycle -> o_pc=0x80. Next cycle, branch alone to 0x40 with i_stall=1 -> o_pc=0x40 (redirect overrides stall).
- In RUN at o_pc=0xC: i_stall=1 for 3 cycles -> o_pc stays 0xC and o_cycles increments by 3. Release the stall -> o_pc=0x10.
- i_step pulses in IDLE from o_pc=0 -> each pulse advances o_pc by 4 and returns to IDLE (o_state 10 then 00). A step with i_stall=1 -> o_pc unchanged, state back to IDLE.
- In RUN at o_pc=0x14: i_halt=1 -> o_halted=1 and o_pc=0x14 thereafter. A later i_run or i_jump has no effect. Assert i_reset mid-halt -> o_pc=0, IDLE, o_cycles=0.
- Wrap-around: jump to 0xFFFF_FFFC, then advance -> o_pc=0x0000_0000. With PC_DEBUG_STEP_EN undefined: an i_step pulse in IDLE -> o_state stays 00 and o_pc is unchanged.

Source files
------------

// File: rtl/pc_controller.sv
// pc_controller: IF-stage program counter with run/step/halt sequencing and a cycle counter.
// Define PC_DEBUG_STEP_EN to enable the single-step (STEP) state driven by i_step.
module pc_controller #(
    parameter int                N_BITS   = 32,
    parameter logic [N_BITS-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_run,
    input  logic              i_step,
    input  logic              i_stall,
    input  logic              i_halt,
    input  logic              i_jump,
    input  logic [N_BITS-1:0] i_jump_addr,
    input  logic              i_branch,
    input  logic [N_BITS-1:0] i_branch_addr,
    output logic [N_BITS-1:0] o_pc,
    output logic [N_BITS-1:0] o_pc_4,
    output logic              o_pc_en,
    output logic [1:0]        o_state,
    output logic              o_halted,
    output logic [31:0]       o_cycles
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STEP = 2'b10, HALTED = 2'b11} state_t;

    state_t            state_q, state_d;
    logic [N_BITS-1:0] pc_q, pc_d, pc_next;
    logic [31:0]       cycles_q, cycles_d;
    logic              halted_q, halted_d;
    logic              active, redirect, halt_take, step_req;

`ifdef PC_DEBUG_STEP_EN
    assign step_req = i_step;
`else
    logic unused_step;
    assign unused_step = i_step;
    assign step_req    = 1'b0;
`endif

    assign active    = (state_q == RUN) || (state_q == STEP);
    assign redirect  = i_jump | i_branch;
    // A redirect squashes a HALT fetched on the wrong path
    assign halt_take = i_halt & ~redirect;
    assign o_pc_4    = pc_q + N_BITS'(4);
    assign pc_next   = i_jump ? i_jump_addr : (i_branch ? i_branch_addr : o_pc_4);
    assign o_pc_en   = active & (redirect | (~i_stall & ~i_halt));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = i_run ? RUN : (step_req ? STEP : IDLE);
            RUN:     state_d = halt_take ? HALTED : RUN;
            STEP:    state_d = halt_take ? HALTED : IDLE;
            default: state_d = HALTED;
        endcase
        pc_d     = o_pc_en ? pc_next : pc_q;
        cycles_d = (active && !(&cycles_q)) ? cycles_q + 32'd1 : cycles_q;
        halted_d = (state_d == HALTED);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            cycles_q <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cycles_q <= cycles_d;
            halted_q <= halted_d;
        end
    end

    assign o_pc     = pc_q;
    assign o_state  = state_q;
    assign o_halted = halted_q;
    assign o_cycles = cycles_q;
endmodule
